xnor_descrambler: RTL and testbench

XNOR_DESCRAMBLER -- requirements
Module: xnor_descrambler

---
 rtl/xnor_pkg.sv | 17 +
 rtl/xnor_lfsr6.sv | 22 ++
 rtl/xnor_descrambler.sv | 59 +++++
 tb/tb_xnor_descrambler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/xnor_pkg.sv
// xnor_pkg: shared constants and helpers for the xnor descrambler.
// Holds the word width, the LFSR tap positions (x^6+x^5+1), the safe
// non-zero seed, and helpers for the LFSR step and zero-seed replacement.
package xnor_pkg;
  localparam int W = 6;
  localparam int TAP_HI = 5;
  localparam int TAP_LO = 4;
  localparam logic [W-1:0] SAFE_SEED = 6'h01;
  typedef logic [W-1:0] word_t;
  function automatic word_t lfsr_next(input word_t k);
    return {k[W-2:0], k[TAP_HI] ^ k[TAP_LO]};
  endfunction
  // An all-zero state would lock the LFSR, so zero maps to the safe seed.
  function automatic word_t safe_seed(input word_t s);
    return (s == '0) ? SAFE_SEED : s;
  endfunction
endpackage

// File: rtl/xnor_lfsr6.sv
// xnor_lfsr6: 6-bit Fibonacci LFSR key generator.
// Ports: clk, rst_n (async active-low), advance (step once), load (take
// load_val, overriding advance), load_val (new seed), key (current key).
module xnor_lfsr6
  import xnor_pkg::*;
#(
  parameter logic [5:0] SEED_RST = 6'h2A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] key
);
  word_t key_q, key_d;
  always_comb key_d = load ? safe_seed(load_val) : advance ? lfsr_next(key_q) : key_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) key_q <= safe_seed(SEED_RST);
    else key_q <= key_d;
  assign key = key_q;
endmodule

// File: rtl/xnor_descrambler.sv
// xnor_descrambler: valid/ready XNOR descrambler with a single output register.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data (upstream),
// seed_load/seed (key reload strobe), out_valid/out_ready/out_data (downstream).
// Macro XNOR_DESCRAMBLER_BYPASS_EN adds input bypass: accepted words pass
// through unchanged and the key holds.
module xnor_descrambler
  import xnor_pkg::*;
#(
  parameter logic [5:0] SEED_RST = 6'h2A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
`ifdef XNOR_DESCRAMBLER_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic  out_valid_q, out_valid_d;
  word_t out_data_q, out_data_d;
  word_t key;
  logic  accept, byp;
`ifdef XNOR_DESCRAMBLER_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  // A new accept refills the register even when the old word leaves this cycle.
  always_comb begin
    out_valid_d = accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d = accept ? (byp ? in_data : ~(in_data ^ key)) : out_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  xnor_lfsr6 #(.SEED_RST(SEED_RST)) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .advance(accept && !byp),
    .load(seed_load),
    .load_val(seed),
    .key(key)
  );
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_xnor_descrambler.sv
// tb_xnor_descrambler: scoreboard bench with directed, hand-computed vectors.
module tb_xnor_descrambler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [5:0] in_data = '0;
  logic seed_load = 1'b0;
  logic [5:0] seed = '0;
  logic out_valid, out_ready = 1'b1;
  logic [5:0] out_data;
  int tests = 0, fails = 0;
  logic [5:0] exp_q[$];
`ifdef XNOR_DESCRAMBLER_BYPASS_EN
  logic bypass = 1'b0;
`endif

  xnor_descrambler dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .seed_load(seed_load),
    .seed(seed),
`ifdef XNOR_DESCRAMBLER_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both are high.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else check("out_data", out_data, exp_q.pop_front());
    end

  task automatic send(input logic [5:0] d, input logic [5:0] exp, input bit push);
    bit ok = 0;
    in_valid = 1'b1;
    in_data = d;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] burst_in[3];
    logic [5:0] burst_exp[3];
    burst_in = '{6'h00, 6'h3F, 6'h2B};
    burst_exp = '{6'h15, 6'h15, 6'h3F};
    repeat (2) @(negedge clk);
    check("rst_out_valid", {5'd0, out_valid}, 6'h00);
    check("rst_out_data", out_data, 6'h00);
    check("rst_in_ready", {5'd0, in_ready}, 6'h01);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(6'h00, 6'h15, 1);
    repeat (2) @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = burst_in[i];
      exp_q.push_back(burst_exp[i]);
      @(negedge clk);
      check("burst_in_ready", {5'd0, in_ready}, 6'h01);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(6'h00, 6'h28, 1);
    fork
      send(6'h2F, 6'h3F, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {5'd0, in_ready}, 6'h00);
          check("stall_out_data", out_data, 6'h28);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(6'h1F, 6'h3F, 1);
    repeat (2) @(posedge clk);
    #1 seed_load = 1'b1;
    seed = 6'h00;
    @(posedge clk);
    #1 seed_load = 1'b0;
    send(6'h01, 6'h3F, 1);
    repeat (2) @(posedge clk);
    #1 do_reset();
    seed_load = 1'b1;
    seed = 6'h10;
    send(6'h00, 6'h15, 1);
    seed_load = 1'b0;
    send(6'h10, 6'h3F, 1);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(6'h05, 6'h00, 0);
    seed_load = 1'b1;
    seed = 6'h33;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    check("seed_keeps_valid", {5'd0, out_valid}, 6'h01);
    check("seed_keeps_data", out_data, 6'h1B);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {5'd0, out_valid}, 6'h00);
    check("async_out_data", out_data, 6'h00);
    check("async_in_ready", {5'd0, in_ready}, 6'h01);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 send(6'h00, 6'h15, 1);
    repeat (3) @(posedge clk);
    #1 check("queue_left", 6'(exp_q.size()), 6'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
